// File: rtl/alu_issuer.sv
// alu_issuer: issues tagged commands into a registered ALU and returns tagged results in issue order.
// Optional build macro ALU_ISSUE_ERRCHK_EN adds a per-command error flag (illegal opcode, divide by zero).
module alu_issuer #(
  parameter int DATA_W     = 16,
  parameter int RES_W      = 32,
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [3:0]        cmd_tag,
  output logic [DATA_W-1:0] alu_operandA,
  output logic [DATA_W-1:0] alu_operandB,
  output logic [3:0]        alu_opcode,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [3:0]        rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = AW + 2;
  localparam logic [SW-1:0] DEPTH_C = SW'(FIFO_DEPTH);

  // Both ports are valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; valid never depends on ready, and payload is held while stalled.
  logic          run_q;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight_count;
  logic [SW-1:0] credit_sum;
  logic          accept;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [ALU_LAT:0] pipe_vld;
  logic [3:0]       pipe_tag [0:ALU_LAT];

  logic [RES_W-1:0] mem_res [FIFO_DEPTH];
  logic [3:0]       mem_tag [FIFO_DEPTH];

  // Credits cover FIFO slots already filled plus those reserved by in-flight ops,
  // so a push can never find the FIFO full without a matching pop.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight_count};
  assign cmd_ready  = run_q && (credit_sum < DEPTH_C);
  assign accept     = cmd_valid && cmd_ready;
  assign push       = pipe_vld[ALU_LAT];
  assign rsp_valid  = (fifo_count != '0);
  assign pop        = rsp_valid && rsp_ready;
  assign busy       = (fifo_count != '0) || (inflight_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q        <= 1'b0;
      alu_operandA <= '0;
      alu_operandB <= '0;
      alu_opcode   <= '0;
      pipe_vld     <= '0;
      for (int i = 0; i <= ALU_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        alu_operandA <= cmd_a;
        alu_operandB <= cmd_b;
        alu_opcode   <= cmd_opcode;
      end
      pipe_vld[0] <= accept;
      pipe_tag[0] <= cmd_tag;
      for (int i = 1; i <= ALU_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_count     <= '0;
      inflight_count <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      case ({accept, push})
        2'b10:   inflight_count <= inflight_count + 1'b1;
        2'b01:   inflight_count <= inflight_count - 1'b1;
        default: ;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; stale entries are never visible because the head is gated by rsp_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_res[wr_ptr] <= alu_result;
      mem_tag[wr_ptr] <= pipe_tag[ALU_LAT];
    end
  end

  assign rsp_result = rsp_valid ? mem_res[rd_ptr] : '0;
  assign rsp_tag    = rsp_valid ? mem_tag[rd_ptr] : '0;

`ifdef ALU_ISSUE_ERRCHK_EN
  logic             acc_err;
  logic [ALU_LAT:0] pipe_err;
  logic             mem_err [FIFO_DEPTH];

  assign acc_err = (cmd_opcode >= 4'b1011) || ((cmd_opcode == 4'b0011) && (cmd_b == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_err <= '0;
    end else begin
      pipe_err[0] <= acc_err;
      for (int i = 1; i <= ALU_LAT; i++) pipe_err[i] <= pipe_err[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_err[wr_ptr] <= pipe_err[ALU_LAT];
  end

  assign rsp_err = rsp_valid && mem_err[rd_ptr];
`else
  assign rsp_err = 1'b0;
`endif

endmodule
